// File: rtl/regfile_arb_pkg.sv
// Shared declarations for the register-file write arbiter.
//   ADDR_W  : register address width of the MIPS register file
//   REGS    : number of architectural registers (2**ADDR_W)
//   src_e   : identifies which writeback source owns a write
//   state_e : occupancy of the single output stage
package regfile_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int REGS   = 2 ** ADDR_W;

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } src_e;

  // IDLE  : nothing presented to the register file
  // WRITE : a write is presented and the register file is accepting
  // HELD  : a write is presented but the register file is frozen
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HELD  = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_write_arbiter_decoder.sv
// Binary-to-one-hot decoder feeding the register-file write enables.
// Ports:
//   a : register address (AW bits)
//   y : one-hot output, bit a is set, all others clear (2**AW bits)
// Purely combinational; the caller gates the result with its own valid.
module regfile_write_arbiter_decoder
  import regfile_arb_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic [AW-1:0]       a,
  output logic [(2**AW)-1:0]  y
);

  generate
    for (genvar gi = 0; gi < (2 ** AW); gi++) begin : g_dec
      assign y[gi] = (a == AW'(gi));
    end
  endgenerate

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the ALU writeback
// (source 0) and the load writeback (source 1). A round-robin arbiter picks
// one source per cycle, the winning write is registered into one output
// stage, and that stage drives the one-hot write enables.
// Ports:
//   clk, rst           : rising-edge clock, synchronous active-low reset
//   req0_* / req1_*    : valid/addr/data in, ready out (combinational)
//   wr_stall           : register file frozen, output stage must hold
//   we                 : one-hot write enables, zero when nothing presented
//   wdata              : write data presented with we
//   wr_fire            : a (nonzero-register) write is presented this cycle
//   grant_id           : source of the presented write
//   drop_r0            : one-cycle pulse, an accepted write to $0 was discarded
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [ADDR_W-1:0]       req0_addr,
  input  logic [DATA_W-1:0]       req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [ADDR_W-1:0]       req1_addr,
  input  logic [DATA_W-1:0]       req1_data,
  output logic                    req1_ready,
  input  logic                    wr_stall,
  output logic [(2**ADDR_W)-1:0]  we,
  output logic [DATA_W-1:0]       wdata,
  output logic                    wr_fire,
  output logic                    grant_id,
  output logic                    drop_r0
);

  import regfile_arb_pkg::*;

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Registered state
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  src_e                src_q,   src_d;
  src_e                rr_q,    rr_d;
  logic                drop_q,  drop_d;

  // Arbitration signals
  logic                out_valid;
  logic                space;
  logic                xfer;
  src_e                grant;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_zero;
  logic [NUM_REGS-1:0] dec_y;

  assign out_valid = (state_q != IDLE);

  // The stage can take a new write when empty or when the presented write
  // retires this cycle (register file not frozen).
  assign space = ~out_valid | ~wr_stall;

  // ------------------------------------------------------------------
  // Round-robin arbitration
  // ------------------------------------------------------------------
  always_comb begin
    grant = SRC_ALU;
    if (req0_valid && req1_valid) begin
      grant = rr_q;
    end else if (req1_valid) begin
      grant = SRC_LOAD;
    end
  end

  always_comb begin
    sel_addr = req0_addr;
    sel_data = req0_data;
    if (grant == SRC_LOAD) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end
  end

  assign sel_zero = (sel_addr == '0);

  // Readys are forced low while reset is asserted so nothing is consumed
  // from the requesters during the reset cycle.
  assign req0_ready = rst & space & req0_valid & (grant == SRC_ALU);
  assign req1_ready = rst & space & req1_valid & (grant == SRC_LOAD);
  assign xfer       = req0_ready | req1_ready;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      src_q   <= SRC_ALU;
      rr_q    <= SRC_ALU;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state and datapath next values
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WRITE, HELD: begin
        // All three states share the same exit rules: a transfer reloads
        // the stage (unless it targets $0), otherwise the stage drains
        // when it has space and is held when it does not.
        if (xfer) begin
          state_d = sel_zero ? IDLE : WRITE;
        end else if (space) begin
          state_d = IDLE;
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    src_d   = src_q;
    rr_d    = rr_q;
    drop_d  = 1'b0;
    if (xfer) begin
      // Priority passes to the other source whether or not the write
      // was to $0, so a stream of $0 writes cannot starve its peer.
      rr_d = src_e'(~grant);
      if (sel_zero) begin
        drop_d = 1'b1;
      end else begin
        addr_d  = sel_addr;
        wdata_d = sel_data;
        src_d   = grant;
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  regfile_write_arbiter_decoder #(
    .AW (ADDR_W)
  ) u_decoder (
    .a (addr_q),
    .y (dec_y)
  );

  always_comb begin
    we       = dec_y & {NUM_REGS{out_valid}};
    wdata    = wdata_q;
    wr_fire  = out_valid;
    grant_id = src_q;
    drop_r0  = drop_q;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port of the MIPS core between two writeback sources: req0 (ALU writeback) and req1 (load writeback).
- Arbitrates round-robin and registers the winning write into one output stage.
- Drives the 32 one-hot write enables through the existing 5-to-32 decoder.
- Sits between the writeback muxing and the register file.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width. REGS = 2**ADDR_W = 32 is derived, not overridable.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the next rising clk).
- req0_valid  in  1  source 0 has a write pending.
- req0_addr  in  ADDR_W  destination register, source 0.
- req0_data  in  DATA_W  write data, source 0.
- req0_ready  out  1  source 0 transfer accepted this cycle (combinational).
- req1_valid  in  1  source 1 has a write pending.
- req1_addr  in  ADDR_W  destination register, source 1.
- req1_data  in  DATA_W  write data, source 1.
- req1_ready  out  1  source 1 transfer accepted this cycle (combinational).
- wr_stall  in  1  register file frozen (debug/scan); holds the output stage.
- we  out  REGS  one-hot register write enables, all zero when idle.
- wdata  out  DATA_W  write data to the register file.
- wr_fire  out  1  a nonzero-register write is presented this cycle.
- grant_id  out  1  source of the currently presented write.
- drop_r0  out  1  1-cycle pulse: an accepted write targeted $0 and was discarded.

Behaviour:
- Reset (rst=0 at posedge) values: out_valid=0, we=0, wdata=0, wr_fire=0, grant_id=0, drop_r0=0, rr_ptr=0 (source 0 has priority first). Reset mid-operation discards any held write with no enable pulse; the readys are 0 while rst=0.
- Output stage is free when: space = ~out_valid | ~wr_stall.
- Arbitration (combinational):
  - Only req0_valid: grant 0. Only req1_valid: grant 1.
  - Both valid: grant rr_ptr.
  - reqN_ready = space & granted(N). A transfer occurs when valid & ready are both high. At most one transfer per cycle.
- rr_ptr: after any transfer, rr_ptr = ~granted source. Unchanged when no transfer.
- Output register, on a transfer at posedge:
  - addr != 0: out_valid=1, wdata=data, grant_id=source, latched addr.
  - addr == 0: out_valid is not set, drop_r0=1 for one cycle. Data is discarded. rr_ptr still advances.
- Output register, no transfer: if space, out_valid=0. Otherwise (stalled) hold all fields.
- Drive: we = decoder(latched addr) gated by out_valid; wr_fire = out_valid. Latency is exactly 1 cycle from transfer to we/wr_fire.
- Stall: while wr_stall=1 and out_valid=1, we/wdata/grant_id stay constant and both readys are 0. On the cycle wr_stall falls, the held write is presented and a new transfer may be accepted in that same cycle.
- Same-address collision (both sources target the same register): serialised by round-robin. The later-granted value is written last.
- No backpressure without stall: back-to-back transfers every cycle. Both sources continuously valid alternate 0,1,0,1,...
- Input rules: requesters must hold valid, addr and data stable until accepted. The block does not check this.
- States: IDLE (out_valid=0), WRITE (out_valid=1, ~wr_stall), HELD (out_valid=1, wr_stall).
  - IDLE -> WRITE on a nonzero transfer.
  - WRITE -> WRITE on a new transfer. WRITE -> IDLE when there is none.
  - WRITE -> HELD when wr_stall=1.
  - HELD -> WRITE/IDLE when wr_stall=0, as above.

Decomposition:
- Package regfile_arb_pkg: ADDR_W, REGS, the src_e typedef (SRC_ALU=0, SRC_LOAD=1), and the state enum (IDLE, WRITE, HELD).
- Sub-module: one instance of the existing decoder (a[4:0] -> y[31:0]) producing the raw one-hot enable. The block ANDs that with out_valid.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both sources valid -> we=0, readys=0, wr_fire=0. Release rst -> first grant goes to source 0.
- Single write: req0 addr=5, data=32'hDEADBEEF for 1 cycle -> next cycle we=32'h00000020, wdata=DEADBEEF, grant_id=0, wr_fire=1; the cycle after, we=0.
- Contention: both valid for 4 cycles (req0 addr=1, req1 addr=2) -> grants alternate 0,1,0,1; we sequence 0x2,0x4,0x2,0x4 with no idle gap.
- $0 drop: req1 addr=0, data=0x1234 -> req1_ready=1, next cycle drop_r0=1, we=0, wr_fire=0. The following contention grants source 0 first.
- Stall: write addr=31 accepted, then wr_stall=1 for 3 cycles with req0 valid -> we=32'h80000000 held constant, req0_ready=0. Release stall -> req0 is accepted the same cycle and its write appears on the next cycle.
- Reset mid-stall: stall holding addr=7, then rst=0 -> next cycle we=0, out_valid cleared, rr_ptr=0.
